// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline: butterfly phase codes and
// twiddle ROM geometry for the 32-point transform.
package fft_pkg;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_FIRST   = 2'b01,
        PH_SECOND  = 2'b10,
        PH_WAITING = 2'b11
    } phase_t;

    localparam int unsigned FFT_N_MAX = 32;
    localparam int unsigned TW_ADDR_W = 5;

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: butterfly phase, shift-register
// enable, twiddle index/address and result valid. Optional FFT_CTRL_FLUSH_EN.
module fft_sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned LOG2N     = 5,
    parameter int unsigned TW_STRIDE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic [1:0]           state,
    output logic                 sr_en,
    output logic                 out_valid,
    output logic [LOG2N-2:0]     tw_idx,
    output logic [TW_ADDR_W-1:0] tw_addr,
    output logic                 frame_done,
    output logic                 err
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned CW = LOG2N - 1;

    phase_t        phase;
    phase_t        phase_next;
    phase_t        state_ph;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          step;

`ifdef FFT_CTRL_FLUSH_EN
    logic [LOG2N-1:0] fill;
    logic [LOG2N-1:0] fill_next;

    // fill_next includes the current cycle so the final SECOND step sees a full count
    assign fill_next = fill + LOG2N'(in_valid);
`endif

    assign cnt_last = (cnt == CW'(H - 1));

    // IDLE shows WAITING as soon as the first sample arrives
    always_comb begin
        state_ph = phase;
        if (phase == PH_IDLE) begin
            state_ph = in_valid ? PH_WAITING : PH_IDLE;
        end
    end

    always_comb begin
        step = in_valid;
`ifdef FFT_CTRL_FLUSH_EN
        if (phase == PH_SECOND) begin
            step = 1'b1;
        end
`endif
    end

    always_comb begin
        phase_next = phase;
        unique case (phase)
            PH_WAITING: phase_next = PH_FIRST;
            PH_FIRST:   phase_next = PH_SECOND;
`ifdef FFT_CTRL_FLUSH_EN
            PH_SECOND:  phase_next = (fill_next == LOG2N'(H)) ? PH_FIRST : PH_IDLE;
`else
            PH_SECOND:  phase_next = PH_FIRST;
`endif
            default:    phase_next = PH_WAITING;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
        end else if (step) begin
            if (phase == PH_IDLE) begin
                phase <= PH_WAITING;
                cnt   <= CW'(1);
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt_last) begin
                    phase <= phase_next;
                end
            end
        end
    end

`ifdef FFT_CTRL_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (phase == PH_FIRST && step && cnt_last) begin
            fill <= '0;
        end else if (phase == PH_SECOND) begin
            fill <= fill_next;
        end
    end

    assign err = step && (phase == PH_SECOND) && cnt_last &&
                 (fill_next != '0) && (fill_next != LOG2N'(H));
`else
    assign err = 1'b0;
`endif

    assign state      = state_ph;
    assign sr_en      = step;
    assign out_valid  = step && (state_ph == PH_FIRST || state_ph == PH_SECOND);
    assign tw_idx     = (state_ph == PH_SECOND) ? cnt : '0;
    assign tw_addr    = TW_ADDR_W'(32'(tw_idx) * TW_STRIDE);
    assign frame_done = step && (state_ph == PH_SECOND) && cnt_last;

endmodule

// File: doc/fft_sdf_stage_ctrl.md
# fft_sdf_stage_ctrl

Sequencer for one radix-2 single-path-delay-feedback (SDF) FFT stage. It drives the 2-bit phase code of the stage's combinational radix-2 butterfly, the shift-register enable, the twiddle index and address, and output valid, counting samples within each half-frame. One instance sits beside each butterfly/shift-register pair in the 32-point pipeline; the `N` parameter selects the stage (32, 16, 8, 4).

## Interface
Parameters:
- `N`, 32: points handled by this stage; power of two, ≥4. Half-frame `H = N/2`.
- `LOG2N`, 5: log2(`N`).
- `TW_STRIDE`, 1: twiddle address step, equal to 32/`N`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  a sample is present on the butterfly A input this cycle.
- `state`  out  2  butterfly phase code: IDLE=00, FIRST=01, SECOND=10, WAITING=11.
- `sr_en`  out  1  shift-register advance enable for this cycle.
- `out_valid`  out  1  butterfly output is a valid result this cycle.
- `tw_idx`  out  LOG2N-1  twiddle exponent k, 0..H-1.
- `tw_addr`  out  5  `tw_idx*TW_STRIDE`, 32-point ROM address.
- `frame_done`  out  1  one-cycle pulse on the last SECOND step of a frame.
- `err`  out  1  one-cycle pulse on a partial next-frame fill (FLUSH build only).

## Operation
- Registers: `phase` (IDLE/WAITING/FIRST/SECOND), `cnt` (LOG2N-1 bits), `fill` (LOG2N bits, FLUSH build only).
- `state` is combinational from `phase`:
  - phase IDLE → `state` = `in_valid` ? WAITING : IDLE.
  - Any other phase → `state` = `phase`.
- `step` (sample advance) = `in_valid` in IDLE/WAITING/FIRST. In SECOND, `step` depends on `FFT_CTRL_FLUSH_EN`; see Configuration.
- On `step`, `cnt` increments modulo H. Phase changes only on a step with `cnt==H-1`:
  - IDLE with `in_valid`: this is WAITING sample 0. Go to `cnt=1`, `phase=WAITING`.
  - WAITING → FIRST.
  - FIRST → SECOND.
  - SECOND → FIRST (next frame's first half is now in the shift register), or → IDLE in the FLUSH build as described under Configuration.
- Outputs:
  - `sr_en` = `step`.
  - `out_valid` = `step` and (`state`==FIRST or `state`==SECOND).
  - `tw_idx` = `cnt` when `state`==SECOND, else 0.
  - `tw_addr` = `tw_idx*TW_STRIDE`, truncated to 5 bits.
  - `frame_done` = `step` and `state`==SECOND and `cnt==H-1`.
- In WAITING and FIRST, a cycle with `in_valid` low freezes `phase`/`cnt`. `sr_en` and `out_valid` are low for that cycle.

## Timing
- Reset values: `phase`=IDLE, `cnt`=0, `fill`=0. Outputs: `state`=00 (with `in_valid` low), `sr_en`/`out_valid`/`frame_done`/`err`=0, `tw_idx`/`tw_addr`=0.
- Reset asserted mid-frame aborts the frame immediately. The first `in_valid` after release is WAITING sample 0.
- Latency is zero: `state`, `tw_*` and `out_valid` describe the sample present on A in the same cycle.
- Minimum frame is 2H `in_valid` cycles, then H SECOND steps. With back-to-back frames the steady state is FIRST(H)/SECOND(H) alternation, with a result every valid cycle.

## Configuration
- `FFT_CTRL_FLUSH_EN` defined (self-draining build):
  - In SECOND, `step`=1 every cycle, so the shift register drains regardless of input.
  - `fill` counts `in_valid` cycles during SECOND.
  - At `cnt==H-1`: `fill==H` → FIRST; `fill==0` → IDLE; otherwise → IDLE with an `err` pulse.
  - `fill` clears on entry to SECOND.
- `FFT_CTRL_FLUSH_EN` undefined (stall build):
  - SECOND steps only on `in_valid`, so the stage stalls until upstream supplies the next frame.
  - SECOND always returns to FIRST; `err` is tied 0.

## Structure
- Shared package `fft_pkg` holds:
  - the phase/state encodings (IDLE, FIRST, SECOND, WAITING);
  - `FFT_N_MAX=32` and the 5-bit twiddle address width.
- The block is a single module; no sub-module is warranted. The twiddle ROM stays external and is addressed by `tw_addr`.

## Test plan
All scenarios use `N=8` (H=4), `TW_STRIDE=4`.
- **Reset:** assert `rst` mid-FIRST, then release → all outputs 0 and `state`=00. The next `in_valid` shows `state`=11 and `cnt` restarts at 0.
- **Single frame, FLUSH build:** 8 contiguous valid cycles, then idle →
  - `state` shows 11×4, then 01×4, then 10×4.
  - `tw_addr` = 0,4,8,12 during SECOND.
  - `frame_done` pulses on the 12th cycle, then `state` returns to 00.
  - `out_valid` is high for cycles 5–12.
- **Back-to-back frames:** 16 contiguous valid cycles → pattern 11×4, 01×4, 10×4, 01×4, 10×4; `err` stays 0.
- **Gap in FIRST:** drop `in_valid` for 2 cycles after FIRST sample 1 → `cnt` holds at 2, and `sr_en`/`out_valid` are 0 for those cycles; the sequence then resumes unchanged.
- **Partial fill, FLUSH build:** only 2 valid cycles during SECOND → `err` pulses with `frame_done`, and `phase` goes to IDLE.
- **Stall build:** input stops after 8 valid cycles → `state` stays 10 with `cnt` at 0 until `in_valid`; 4 further valid cycles then produce FIRST.
